seg7_scan_ctrl: RTL

- Time-multiplexed scan controller for a multi-digit common-anode 7-segment display.
- A single bcd_to_7seg_2bits decoder is shared across NUM_DIGITS digits.
- Holds a double-buffered frame of 2-bit digit values and cycles one digit at a time onto the shared bcd_out bus, driving the matching active-low anode.
- Inserts blanking intervals between digits to suppress ghosting; sits between the application logic and the decoder/anode pins.

---
 rtl/seg7_pkg.sv | 6 +
 rtl/seg7_phase_timer.sv | 27 ++
 rtl/seg7_scan_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared types for the 7-segment scan controller.
package seg7_pkg;
  typedef enum logic [1:0] {S_IDLE, S_SHOW, S_BLANK} scan_state_t;
  localparam int DIGIT_W = 2;
  typedef logic [DIGIT_W-1:0] digit_t;
endpackage

// File: rtl/seg7_phase_timer.sv
// Loadable down-counter; expire_o is high during the last cycle of a phase.
module seg7_phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             expire_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expire_o = (cnt_q == CNT_W'(1));
endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed scan controller for a common-anode 7-segment display with a
// double-buffered frame. Define SEG7_LZB_EN to enable leading-zero blanking.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          load,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] data_in,
  output logic [DIGIT_W-1:0]            bcd_out,
  output logic [NUM_DIGITS-1:0]         digit_an,
  output logic                          frame_done
);
  localparam int MAX_PH  = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(MAX_PH + 1);
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int FRAME_W = DIGIT_W * NUM_DIGITS;
  localparam logic [CNT_W-1:0] SHOW_LEN  = CNT_W'(REFRESH_DIV);
  localparam logic [CNT_W-1:0] BLANK_LEN = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);

  scan_state_t          state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d, idx_nxt;
  logic [FRAME_W-1:0]   pend_q, pend_d, act_q, act_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  digit_t               bcd_q, bcd_d;
  logic                 fd_q, fd_d;
  logic                 t_load, t_expire;
  logic [CNT_W-1:0]     t_val;

  function automatic digit_t digit_of(input logic [FRAME_W-1:0] f,
                                      input logic [IDX_W-1:0] i);
    return f[int'(i)*DIGIT_W +: DIGIT_W];
  endfunction

  // A digit is dark when it and every more significant digit are zero.
  function automatic logic lzb_dark(input logic [FRAME_W-1:0] f,
                                    input logic [IDX_W-1:0] i);
    logic dark;
    dark = 1'b0;
`ifdef SEG7_LZB_EN
    dark = (i != '0);
    for (int j = 0; j < NUM_DIGITS; j++)
      if (j >= int'(i) && f[j*DIGIT_W +: DIGIT_W] != '0) dark = 1'b0;
`endif
    return dark;
  endfunction

  seg7_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (t_load),
    .load_val_i (t_val),
    .expire_o   (t_expire)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pend_d  = load ? data_in : pend_q;
    act_d   = act_q;
    t_load  = 1'b0;
    t_val   = '0;
    fd_d    = 1'b0;
    idx_nxt = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);

    if (!enable) begin
      state_d = S_IDLE;
      idx_d   = '0;
      t_load  = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_SHOW;
          idx_d   = '0;
          act_d   = pend_q;
          t_load  = 1'b1;
          t_val   = SHOW_LEN;
        end
        S_SHOW: begin
          if (t_expire) begin
            fd_d   = (idx_q == LAST_IDX);
            t_load = 1'b1;
            if (BLANK_CYCLES > 0) begin
              state_d = S_BLANK;
              t_val   = BLANK_LEN;
            end else begin
              idx_d = idx_nxt;
              t_val = SHOW_LEN;
              if (idx_nxt == '0) act_d = pend_q;
            end
          end
        end
        S_BLANK: begin
          if (t_expire) begin
            state_d = S_SHOW;
            idx_d   = idx_nxt;
            t_load  = 1'b1;
            t_val   = SHOW_LEN;
            if (idx_nxt == '0) act_d = pend_q;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs are registered from the next state so anode and value move together.
    an_d  = '1;
    bcd_d = bcd_q;
    if (state_d == S_SHOW) begin
      bcd_d = digit_of(act_d, idx_d);
      if (!lzb_dark(act_d, idx_d)) an_d[idx_d] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      pend_q  <= '0;
      act_q   <= '0;
      an_q    <= '1;
      bcd_q   <= '0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      act_q   <= act_d;
      an_q    <= an_d;
      bcd_q   <= bcd_d;
      fd_q    <= fd_d;
    end
  end

  assign digit_an   = an_q;
  assign bcd_out    = bcd_q;
  assign frame_done = fd_q;
endmodule
